uart_frame_loader: RTL

Parametrised program loader that receives an oversampled 8N1 serial stream and writes bytes into program memory through a single-strobe write port. It supersedes the fixed 21-bit streaming loader: address width, oversampling ratio and write-pulse length are parameters, and an optional framed mode adds address-set commands, length-delimited data blocks, checksums and error flags. It sits between the host serial pin and the boot RAM write mux.

---
 rtl/loader_pkg.sv | 35 +++
 rtl/uart_frame_loader_if.sv | 24 ++
 rtl/uart_rx_os.sv | 82 ++++++++
 rtl/uart_frame_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the serial program loader: state enums and opcodes.
// Used by uart_rx_os and uart_frame_loader.
package loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        EN_IDLE,
        EN_LATCH,
        EN_WRITE,
        EN_INC
    } eng_state_t;

    typedef enum logic [2:0] {
        C_CMD,
        C_ADDR,
        C_LEN,
        C_DATA,
        C_SUM
    } cmd_state_t;

    localparam logic [7:0] OP_ADDR  = 8'h41;
    localparam logic [7:0] OP_WRITE = 8'h57;

    // Bytes needed to carry an address of width w.
    function automatic int addr_bytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Memory write port and status flags of the loader.
// master: loader drives adr/data/write/busy/done/err_*; slave: observer.
interface uart_frame_loader_if #(
    parameter int ADR_W = 21
);
    logic [ADR_W-1:0] adr;
    logic [7:0]       data;
    logic             write;
    logic             busy;
    logic             done;
    logic             err_cksum;
    logic             err_frame;
    logic             err_ovr;

    modport master (
        output adr, data, write, busy, done,
        output err_cksum, err_frame, err_ovr
    );

    modport slave (
        input adr, data, write, busy, done,
        input err_cksum, err_frame, err_ovr
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 receiver with 2-FF synchroniser and glitch rejection.
// Ports: clk, reset_n, rx in; rx_valid/rx_ferr pulses, rx_byte out.
module uart_rx_os
    import loader_pkg::*;
#(
    parameter int OSR = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);
    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] HALF = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OSR - 1);

    logic            s1_q, s2_q;
    rx_state_t       st_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      sh_q;

    assign rx_byte = sh_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            st_q     <= RX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            s1_q     <= rx;
            s2_q     <= s1_q;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (st_q)
                RX_IDLE: begin
                    if (!s2_q) begin
                        st_q  <= RX_START;
                        cnt_q <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start check: a short low pulse is a glitch.
                    if (cnt_q == HALF) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        st_q  <= s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL) begin
                        cnt_q <= '0;
                        sh_q  <= {s2_q, sh_q[7:1]};
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 3'd7) st_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL) begin
                        rx_valid <= s2_q;
                        rx_ferr  <= !s2_q;
                        st_q     <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: st_q <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_frame_loader.sv
// Serial program loader: command FSM plus single-strobe write engine.
// Ports: clk, reset_n, rx in; bus (master) carries adr/data/write/flags.
module uart_frame_loader
    import loader_pkg::*;
#(
    parameter int ADR_W    = 21,
    parameter int OSR      = 12,
    parameter int WR_PULSE = 1,
    parameter int FRAMED   = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rx,
    uart_frame_loader_if.master bus
);
    localparam int NAB = addr_bytes(ADR_W);
    localparam int WCW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(WR_PULSE - 1);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_os #(.OSR(OSR)) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    eng_state_t       eng_q;
    cmd_state_t       cmd_q;
    logic [ADR_W-1:0] adr_q;
    logic [ADR_W-1:0] stage_q;
    logic [ADR_W-1:0] stage_nx;
    logic [7:0]       data_q;
    logic             write_q;
    logic [WCW-1:0]   wcnt_q;
    logic [3:0]       ab_q;
    logic [8:0]       rem_q;
    logic [7:0]       sum_q;
    logic             done_q;
    logic             err_cksum_q;
    logic             err_frame_q;
    logic             err_ovr_q;

    // Drop the incoming address byte into its slot; bits past ADR_W fall off.
    always_comb begin
        stage_nx = stage_q;
        for (int b = 0; b < 8; b++) begin
            if (int'(ab_q) * 8 + b < ADR_W)
                stage_nx[int'(ab_q) * 8 + b] = rx_byte[b];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_q       <= EN_IDLE;
            cmd_q       <= C_CMD;
            adr_q       <= '0;
            stage_q     <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            wcnt_q      <= '0;
            ab_q        <= '0;
            rem_q       <= '0;
            sum_q       <= '0;
            done_q      <= 1'b0;
            err_cksum_q <= 1'b0;
            err_frame_q <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rx_ferr) err_frame_q <= 1'b1;

            case (eng_q)
                EN_LATCH: begin
                    eng_q   <= EN_WRITE;
                    write_q <= 1'b1;
                    wcnt_q  <= '0;
                end
                EN_WRITE: begin
                    if (wcnt_q == WLAST) begin
                        write_q <= 1'b0;
                        eng_q   <= EN_INC;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                EN_INC: begin
                    adr_q <= adr_q + 1'b1;
                    eng_q <= EN_IDLE;
                end
                default: ;
            endcase

            // A byte only lands when the engine is idle, so the engine
            // case above never competes with these assignments.
            if (rx_valid) begin
                if (eng_q != EN_IDLE) begin
                    err_ovr_q <= 1'b1;
                end else if (FRAMED == 0) begin
                    data_q <= rx_byte;
                    eng_q  <= EN_LATCH;
                end else begin
                    case (cmd_q)
                        C_CMD: begin
                            unique case (1'b1)
                                (rx_byte == OP_ADDR): begin
                                    cmd_q <= C_ADDR;
                                    ab_q  <= '0;
                                end
                                (rx_byte == OP_WRITE): cmd_q <= C_LEN;
                                default: ;
                            endcase
                        end
                        C_ADDR: begin
                            stage_q <= stage_nx;
                            ab_q    <= ab_q + 1'b1;
                            if (ab_q == 4'(NAB - 1)) begin
                                adr_q <= stage_nx;
                                cmd_q <= C_CMD;
                            end
                        end
                        C_LEN: begin
                            rem_q <= (rx_byte == 8'd0) ? 9'd256
                                                       : {1'b0, rx_byte};
                            sum_q <= '0;
                            cmd_q <= C_DATA;
                        end
                        C_DATA: begin
                            data_q <= rx_byte;
                            eng_q  <= EN_LATCH;
                            sum_q  <= sum_q + rx_byte;
                            rem_q  <= rem_q - 9'd1;
                            if (rem_q == 9'd1) cmd_q <= C_SUM;
                        end
                        C_SUM: begin
                            if (rx_byte == sum_q) done_q <= 1'b1;
                            else err_cksum_q <= 1'b1;
                            cmd_q <= C_CMD;
                        end
                        default: cmd_q <= C_CMD;
                    endcase
                end
            end
        end
    end

    assign bus.adr       = adr_q;
    assign bus.data      = data_q;
    assign bus.write     = write_q;
    assign bus.busy      = (cmd_q != C_CMD) || (eng_q != EN_IDLE);
    assign bus.done      = done_q;
    assign bus.err_cksum = err_cksum_q;
    assign bus.err_frame = err_frame_q;
    assign bus.err_ovr   = err_ovr_q;
endmodule
